// File: rtl/volume_ramp_if.sv
// Signal bundle between the volume stage and its neighbours: downstream pop/ack,
// upstream pop/ack, the shared multiplier port and the gain/mute controls.
interface volume_ramp_if;
  logic [1:0]  pop_i;
  logic [23:0] data_o;
  logic [1:0]  ack_o;
  logic [1:0]  pop_o;
  logic [23:0] data_i;
  logic [1:0]  ack_i;
  logic        mpready_i;
  logic [23:0] mpcand_o;
  logic [15:0] mplier_o;
  logic [23:0] mprod_i;
  logic [15:0] gain_i;
  logic [1:0]  gain_we_i;
  logic        mute_i;

  modport slave (
    input  pop_i, data_i, ack_i, mpready_i, mprod_i, gain_i, gain_we_i, mute_i,
    output data_o, ack_o, pop_o, mpcand_o, mplier_o
  );

  modport master (
    output pop_i, data_i, ack_i, mpready_i, mprod_i, gain_i, gain_we_i, mute_i,
    input  data_o, ack_o, pop_o, mpcand_o, mplier_o
  );
endinterface

// File: rtl/volume_ramp.sv
// Per-channel L/R gain stage with linear click-free ramp; pop_i->pop_o 2 cycles, ack_i->ack_o <= 2+MP_LATENCY.
// Backpressure: one transaction at a time, waits on upstream ack (timeout -> zero) and on mpready_i.
module volume_ramp #(
  parameter logic [15:0] RAMP_STEP  = 16'd64,
  parameter logic [15:0] GAIN_RST   = 16'h0000,
  parameter int          MP_LATENCY = 2,
  parameter logic [7:0]  TIMEOUT    = 8'd48
) (
  input logic          clk,
  input logic          rst,
  volume_ramp_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WACK, S_WMP, S_MUL, S_OUT} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_ch;
  logic [1:0]  r_pending;
  logic [7:0]  r_timer;
  logic [23:0] r_sample;
  logic [3:0]  r_mcnt;
  logic [23:0] r_data;
  logic [15:0] r_cur [2];
  logic [15:0] r_tgt [2];

  logic        w_take;
  logic        w_pick;
  logic        w_load_out;
  logic [23:0] w_result;
  logic [15:0] w_cur;
  logic        w_gain_zero;
  logic        w_gain_unity;
  logic        w_ack_ch;
  logic        w_timeout;
  logic        w_mul_done;
  logic [15:0] w_tgt_nxt [2];
  logic [15:0] w_eff;
  logic [15:0] w_delta;
  logic [15:0] w_cur_nxt;

  assign w_cur        = r_cur[r_ch];
  assign w_gain_zero  = (w_cur == 16'h0000);
  assign w_gain_unity = (w_cur == 16'hFFFF);
  assign w_ack_ch     = bus.ack_i[r_ch];
  assign w_timeout    = (r_timer >= (TIMEOUT - 8'd1));
  assign w_mul_done   = (r_mcnt == 4'(MP_LATENCY - 1));
  assign bus.data_o   = r_data;

  always_comb begin
    w_state_nxt  = r_state;
    w_take       = 1'b0;
    w_pick       = 1'b0;
    w_load_out   = 1'b0;
    w_result     = '0;
    bus.pop_o    = '0;
    bus.ack_o    = '0;
    bus.mpcand_o = '0;
    bus.mplier_o = '0;
    unique case (r_state)
      S_IDLE: begin
        if (|r_pending) begin
          w_take      = 1'b1;
          w_pick      = ~r_pending[0];
          w_state_nxt = S_REQ;
        end
      end
      S_REQ: begin
        bus.pop_o   = r_ch ? 2'b10 : 2'b01;
        w_state_nxt = S_WACK;
      end
      S_WACK: begin
        if (w_ack_ch || w_timeout) w_state_nxt = S_WMP;
      end
      S_WMP: begin
        // zero and unity gain never touch the shared multiplier
        if (w_gain_zero) begin
          w_load_out  = 1'b1;
          w_state_nxt = S_OUT;
        end else if (w_gain_unity) begin
          w_load_out  = 1'b1;
          w_result    = r_sample;
          w_state_nxt = S_OUT;
        end else if (bus.mpready_i) begin
          bus.mpcand_o = r_sample;
          bus.mplier_o = w_cur;
          w_state_nxt  = S_MUL;
        end
      end
      S_MUL: begin
        bus.mpcand_o = r_sample;
        bus.mplier_o = w_cur;
        if (w_mul_done) begin
          w_load_out  = 1'b1;
          w_result    = bus.mprod_i;
          w_state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        bus.ack_o   = r_ch ? 2'b10 : 2'b01;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A gain write landing in the same cycle as OUT steers that ramp step.
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      w_tgt_nxt[c] = bus.gain_we_i[c] ? bus.gain_i : r_tgt[c];
    end
    w_eff     = bus.mute_i ? 16'h0000 : w_tgt_nxt[r_ch];
    w_delta   = '0;
    w_cur_nxt = w_cur;
    if (w_eff > w_cur) begin
      w_delta   = w_eff - w_cur;
      w_cur_nxt = w_cur + ((w_delta > RAMP_STEP) ? RAMP_STEP : w_delta);
    end else begin
      w_delta   = w_cur - w_eff;
      w_cur_nxt = w_cur - ((w_delta > RAMP_STEP) ? RAMP_STEP : w_delta);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_ch      <= 1'b0;
      r_pending <= '0;
      r_timer   <= '0;
      r_sample  <= '0;
      r_mcnt    <= '0;
      r_data    <= '0;
      for (int c = 0; c < 2; c++) begin
        r_cur[c] <= GAIN_RST;
        r_tgt[c] <= GAIN_RST;
      end
    end else begin
      r_state <= w_state_nxt;
      for (int c = 0; c < 2; c++) begin
        // a pop for the channel already being served is dropped
        if (w_take && (w_pick == 1'(c))) begin
          r_pending[c] <= 1'b0;
        end else if (bus.pop_i[c] && !((r_state != S_IDLE) && (r_ch == 1'(c)))) begin
          r_pending[c] <= 1'b1;
        end
        r_tgt[c] <= w_tgt_nxt[c];
      end
      if (w_take) r_ch <= w_pick;
      if (r_state == S_REQ) begin
        r_timer <= '0;
      end else if (r_state == S_WACK) begin
        r_timer <= r_timer + 8'd1;
      end
      if (r_state == S_WACK) begin
        if (w_ack_ch) begin
          r_sample <= bus.data_i;
        end else if (w_timeout) begin
          r_sample <= '0;
        end
      end
      if (r_state == S_WMP) begin
        r_mcnt <= '0;
      end else if (r_state == S_MUL) begin
        r_mcnt <= r_mcnt + 4'd1;
      end
      if (w_load_out) r_data <= w_result;
      if (r_state == S_OUT) r_cur[r_ch] <= w_cur_nxt;
    end
  end

endmodule

// File: tb/tb_volume_ramp.sv
// Directed + randomized bench for volume_ramp with an upstream responder, a
// 2-cycle multiplier model and a per-channel sample/gain reference model.
module tb_volume_ramp;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  volume_ramp_if bus ();
  volume_ramp dut (.clk(clk), .rst(rst), .bus(bus));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [23:0] q_l [$];
  logic [23:0] q_r [$];
  int model_cur [2];
  int model_tgt [2];
  int ramp_ch = -1;
  int ack_cnt = 0;
  int ack_order [$];
  int popo_order [$];
  int last_popo_cyc = 0;
  int last_ack_cyc  = 0;
  int last_acki_cyc = 0;

  bit          noack       = 1'b0;
  bit          fix_vld     = 1'b0;
  logic [23:0] fix_dat     = '0;
  int          ack_dly_max = 3;

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mul_q16(input logic [23:0] a, input logic [15:0] b);
    logic signed [40:0] p;
    p = $signed(a) * $signed({1'b0, b});
    return p[39:16];
  endfunction

  // Reference: zero gain mutes, full-scale gain is exact pass-through, else Q0.16 scaling.
  function automatic logic [23:0] expect_out(input logic [23:0] s, input int g);
    longint p;
    if (g == 0) return 24'h0;
    if (g == 65535) return s;
    p = longint'($signed(s)) * longint'(g);
    p = p >>> 16;
    return p[23:0];
  endfunction

  task automatic push_s(input int c, input logic [23:0] d);
    if (c == 0) q_l.push_back(d);
    else q_r.push_back(d);
  endtask

  logic [23:0] mp_p1 = '0;
  logic [23:0] mp_p2 = '0;
  always @(posedge clk) begin
    mp_p1 <= mul_q16(bus.mpcand_o, bus.mplier_o);
    mp_p2 <= mp_p1;
  end
  assign bus.mprod_i = mp_p2;

  // upstream resampler
  initial begin
    int rch;
    int dly;
    logic [23:0] d;
    bus.ack_i  = '0;
    bus.data_i = '0;
    forever begin
      @(negedge clk);
      if (bus.pop_o != 2'b00 && !rst) begin
        rch = bus.pop_o[1] ? 1 : 0;
        if (noack) begin
          push_s(rch, 24'h0);
        end else begin
          dly = $urandom_range(1, ack_dly_max);
          repeat (dly - 1) @(negedge clk);
          if (dly >= 2 && $urandom_range(0, 1) == 1) begin
            bus.ack_i  = (rch == 1) ? 2'b01 : 2'b10;
            bus.data_i = 24'($urandom);
          end
          @(negedge clk);
          d = fix_vld ? fix_dat : 24'($urandom);
          fix_vld = 1'b0;
          bus.data_i = d;
          bus.ack_i  = (rch == 1) ? 2'b10 : 2'b01;
          push_s(rch, d);
          last_acki_cyc = cyc;
          @(negedge clk);
          bus.ack_i = '0;
        end
      end
    end
  end

  // output monitor and gain model
  initial begin
    int ch;
    int qs;
    int eff;
    int step;
    logic [23:0] s;
    forever begin
      @(negedge clk);
      if (bus.pop_o != 2'b00) begin
        popo_order.push_back(bus.pop_o[1] ? 1 : 0);
        last_popo_cyc = cyc;
      end
      if (bus.ack_o != 2'b00) begin
        chk("ack_onehot", 48'($onehot(bus.ack_o)), 48'd1);
        ch = bus.ack_o[1] ? 1 : 0;
        ack_cnt++;
        ack_order.push_back(ch);
        last_ack_cyc = cyc;
        qs = (ch == 0) ? q_l.size() : q_r.size();
        chk("ack_has_sample", 48'(qs > 0), 48'd1);
        if (qs > 0) begin
          s = (ch == 0) ? q_l.pop_front() : q_r.pop_front();
          chk("data_o", 48'(bus.data_o), 48'(expect_out(s, model_cur[ch])));
          ramp_ch = ch;
        end
      end
      @(posedge clk);
      cyc++;
      if (rst) begin
        model_cur[0] = 0; model_cur[1] = 0;
        model_tgt[0] = 0; model_tgt[1] = 0;
        q_l.delete(); q_r.delete();
        ramp_ch = -1;
      end else begin
        for (int c = 0; c < 2; c++) if (bus.gain_we_i[c]) model_tgt[c] = int'(bus.gain_i);
        if (ramp_ch >= 0) begin
          eff  = bus.mute_i ? 0 : model_tgt[ramp_ch];
          step = eff - model_cur[ramp_ch];
          if (step > 64) step = 64;
          if (step < -64) step = -64;
          model_cur[ramp_ch] = model_cur[ramp_ch] + step;
          ramp_ch = -1;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "bench did not complete");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_pop(input logic [1:0] m);
    @(negedge clk); bus.pop_i = m;
    @(negedge clk); bus.pop_i = 2'b00;
  endtask

  task automatic write_gain(input logic [1:0] m, input logic [15:0] g);
    @(negedge clk); bus.gain_i = g; bus.gain_we_i = m;
    @(negedge clk); bus.gain_we_i = 2'b00;
  endtask

  task automatic wait_acks(input string tag, input int target, input int budget);
    int k = 0;
    while (ack_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, 48'(ack_cnt >= target), 48'd1);
  endtask

  task automatic pop_and_wait(input logic [1:0] m, input string tag);
    int tgt;
    tgt = ack_cnt + $countones(m);
    pulse_pop(m);
    wait_acks(tag, tgt, 300);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    int base;
    int k;
    int t0;
    bit bad;
    rst = 1'b1;
    bus.pop_i = '0; bus.gain_i = '0; bus.gain_we_i = '0;
    bus.mute_i = 1'b0; bus.mpready_i = 1'b1;
    tick(3);
    chk("rst_pop_o", 48'(bus.pop_o), 48'h0);
    chk("rst_ack_o", 48'(bus.ack_o), 48'h0);
    chk("rst_data_o", 48'(bus.data_o), 48'h0);
    chk("rst_mpcand", 48'(bus.mpcand_o), 48'h0);
    chk("rst_mplier", 48'(bus.mplier_o), 48'h0);
    rst = 1'b0;

    // R ramps up from mute by 64 per sample
    write_gain(2'b10, 16'hFFFF);
    fix_dat = 24'h7FFF00; fix_vld = 1'b1;
    pop_and_wait(2'b10, "t2_ack0");
    chk("t2_gain0", 48'(bus.data_o), 48'h0);
    fix_dat = 24'h400000; fix_vld = 1'b1;
    pop_and_wait(2'b10, "t2_ack1");
    chk("t2_gain64", 48'(bus.data_o), 48'h001000);
    fix_dat = 24'h400000; fix_vld = 1'b1;
    pop_and_wait(2'b10, "t2_ack2");
    chk("t2_gain128", 48'(bus.data_o), 48'h002000);
    pop_and_wait(2'b10, "t2_ack3");

    // full ramp to unity on L, with a signed multiply at half gain on the way
    do_reset();
    write_gain(2'b11, 16'hFFFF);
    for (int i = 0; i < 1024; i++) begin
      if (i == 512) begin
        base = ack_cnt;
        fix_dat = 24'hF00000; fix_vld = 1'b1;
        pulse_pop(2'b01);
        k = 0;
        while (bus.mpcand_o == 24'h0 && k < 100) begin @(negedge clk); k++; end
        chk("t3_mpcand", 48'(bus.mpcand_o), 48'hF00000);
        chk("t3_mplier", 48'(bus.mplier_o), 48'h8000);
        wait_acks("t3_ack", base + 1, 300);
        chk("t3_data", 48'(bus.data_o), 48'hF80000);
        chk("t3_ack_latency", 48'((last_ack_cyc - last_acki_cyc) <= 4), 48'd1);
      end else begin
        pop_and_wait(2'b01, "t1_ramp_ack");
      end
    end
    fix_dat = 24'h123400; fix_vld = 1'b1;
    pop_and_wait(2'b01, "t1_bypass_ack");
    chk("t1_bypass_data", 48'(bus.data_o), 48'h123400);

    // simultaneous pops and dropped duplicates
    tick(5);
    popo_order.delete(); ack_order.delete();
    base = ack_cnt;
    @(negedge clk); bus.pop_i = 2'b11;
    @(negedge clk); bus.pop_i = 2'b10;
    @(negedge clk); bus.pop_i = 2'b01;
    @(negedge clk); bus.pop_i = 2'b00;
    wait_acks("t4_acks", base + 2, 300);
    tick(30);
    chk("t4_ack_count", 48'(ack_cnt - base), 48'd2);
    chk("t4_popo_count", 48'(popo_order.size()), 48'd2);
    if (popo_order.size() >= 2 && ack_order.size() >= 2) begin
      chk("t4_popo_first_L", 48'(popo_order[0]), 48'd0);
      chk("t4_popo_second_R", 48'(popo_order[1]), 48'd1);
      chk("t4_ack_first_L", 48'(ack_order[0]), 48'd0);
      chk("t4_ack_second_R", 48'(ack_order[1]), 48'd1);
    end

    // upstream silence -> zero sample after the timeout, then idle again
    noack = 1'b1;
    base = ack_cnt;
    pulse_pop(2'b01);
    wait_acks("t5_timeout_ack", base + 1, 200);
    noack = 1'b0;
    chk("t5_data", 48'(bus.data_o), 48'h0);
    chk("t5_timeout_window",
        48'(((last_ack_cyc - last_popo_cyc) >= 48) && ((last_ack_cyc - last_popo_cyc) <= 52)), 48'd1);
    tick(3);
    @(negedge clk); t0 = cyc; base = ack_cnt; bus.pop_i = 2'b01;
    @(negedge clk); bus.pop_i = 2'b00;
    wait_acks("t5_next_ack", base + 1, 300);
    chk("t5_pop_latency", 48'(last_popo_cyc - t0), 48'd2);

    // multiplier busy: no operand issue and no ack until ready
    write_gain(2'b01, 16'h4000);
    pop_and_wait(2'b01, "t6_pre_ack");
    bus.mpready_i = 1'b0;
    base = ack_cnt;
    fix_dat = 24'h234567; fix_vld = 1'b1;
    pulse_pop(2'b01);
    bad = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (bus.mpcand_o != 24'h0 || bus.ack_o != 2'b00) bad = 1'b1;
    end
    chk("t6_no_issue_while_busy", 48'(bad), 48'd0);
    bus.mpready_i = 1'b1;
    wait_acks("t6_ack_after_ready", base + 1, 100);

    // reset in the middle of a multiply aborts the transaction
    base = ack_cnt;
    fix_dat = 24'h100000; fix_vld = 1'b1;
    pulse_pop(2'b01);
    k = 0;
    while (bus.mpcand_o == 24'h0 && k < 100) begin @(negedge clk); k++; end
    chk("t6_issue_seen", 48'(bus.mpcand_o != 24'h0), 48'd1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    chk("t6_rst_pop_o", 48'(bus.pop_o), 48'h0);
    chk("t6_rst_ack_o", 48'(bus.ack_o), 48'h0);
    chk("t6_rst_data_o", 48'(bus.data_o), 48'h0);
    chk("t6_rst_mpcand", 48'(bus.mpcand_o), 48'h0);
    chk("t6_rst_mplier", 48'(bus.mplier_o), 48'h0);
    tick(15);
    chk("t6_no_ack_after_rst", 48'(ack_cnt - base), 48'd0);

    // randomized traffic, gain writes, mute and multiplier availability
    ack_dly_max = 6;
    base = ack_cnt;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      bus.pop_i = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      if ($urandom_range(0, 60) == 0) begin
        bus.gain_we_i = 2'($urandom_range(1, 3));
        case ($urandom_range(0, 3))
          0:       bus.gain_i = 16'h0000;
          1:       bus.gain_i = 16'hFFFF;
          default: bus.gain_i = 16'($urandom);
        endcase
      end else begin
        bus.gain_we_i = 2'b00;
      end
      if ($urandom_range(0, 299) == 0) bus.mute_i = ~bus.mute_i;
      bus.mpready_i = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    bus.pop_i = 2'b00; bus.gain_we_i = 2'b00; bus.mute_i = 1'b0; bus.mpready_i = 1'b1;
    tick(300);
    chk("rand_drained_L", 48'(q_l.size()), 48'd0);
    chk("rand_drained_R", 48'(q_r.size()), 48'd0);
    chk("rand_acks_seen", 48'(ack_cnt > base + 50), 48'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
